// File: rtl/udp_pkg.sv
// Shared UDP header definitions for the UDP demux slice.
// The Ethernet, IP and UDP header fields are packed into one 336-bit vector.
// Fields are listed from bit 0 upward; each *_OFFSET is the LSB of that field.
package udp_pkg;

    localparam int UDP_HDR_WIDTH = 336;

    localparam int ETH_DEST_MAC_OFFSET  = 0;    // 48 bits
    localparam int ETH_SRC_MAC_OFFSET   = 48;   // 48 bits
    localparam int ETH_TYPE_OFFSET      = 96;   // 16 bits
    localparam int IP_VERSION_OFFSET    = 112;  // 4 bits
    localparam int IP_IHL_OFFSET        = 116;  // 4 bits
    localparam int IP_DSCP_OFFSET       = 120;  // 6 bits
    localparam int IP_ECN_OFFSET        = 126;  // 2 bits
    localparam int IP_LENGTH_OFFSET     = 128;  // 16 bits
    localparam int IP_ID_OFFSET         = 144;  // 16 bits
    localparam int IP_FLAGS_OFFSET      = 160;  // 3 bits
    localparam int IP_FRAG_OFFSET       = 163;  // 13 bits
    localparam int IP_TTL_OFFSET        = 176;  // 8 bits
    localparam int IP_PROTOCOL_OFFSET   = 184;  // 8 bits
    localparam int IP_HDR_CSUM_OFFSET   = 192;  // 16 bits
    localparam int IP_SRC_IP_OFFSET     = 208;  // 32 bits
    localparam int IP_DEST_IP_OFFSET    = 240;  // 32 bits
    localparam int UDP_SRC_PORT_OFFSET  = 272;  // 16 bits
    localparam int UDP_DEST_PORT_OFFSET = 288;  // 16 bits
    localparam int UDP_LENGTH_OFFSET    = 304;  // 16 bits
    localparam int UDP_CSUM_OFFSET      = 320;  // 16 bits

    // Demux frame state: waiting for a header, or moving payload of one frame.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } demux_state_t;

endpackage

// File: rtl/udp_demux_out_buf.sv
// Per-port payload output register for udp_demux.
// UDP_DEMUX_SKID_EN defined  : 2-entry skid buffer, full throughput, registered in_tready.
// UDP_DEMUX_SKID_EN undefined: single register, in_tready = !valid || out_tready (combinational).
module udp_demux_out_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_tdata,
    input  logic [KEEP_WIDTH-1:0] in_tkeep,
    input  logic                  in_tlast,
    input  logic [USER_WIDTH-1:0] in_tuser,
    input  logic                  in_tvalid,
    output logic                  in_tready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic [KEEP_WIDTH-1:0] out_tkeep,
    output logic                  out_tlast,
    output logic [USER_WIDTH-1:0] out_tuser,
    output logic                  out_tvalid,
    input  logic                  out_tready
);

    localparam int BEAT_WIDTH = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    logic [BEAT_WIDTH-1:0] in_beat;
    logic [BEAT_WIDTH-1:0] out_beat_q, out_beat_d;
    logic                  out_valid_q, out_valid_d;

    assign in_beat = {in_tdata, in_tkeep, in_tuser, in_tlast};

`ifdef UDP_DEMUX_SKID_EN
    logic [BEAT_WIDTH-1:0] tmp_beat_q, tmp_beat_d;
    logic                  tmp_valid_q, tmp_valid_d;
    logic                  ready_q, ready_d;

    // Skid control: ready is registered, so one beat may land while the output stalls.
    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        tmp_valid_d = tmp_valid_q;
        tmp_beat_d  = tmp_beat_q;
        ready_d     = out_tready || (!tmp_valid_q && (!out_valid_q || !in_tvalid));
        if (ready_q) begin
            if (out_tready || !out_valid_q) begin
                out_valid_d = in_tvalid;
                out_beat_d  = in_beat;
            end else begin
                tmp_valid_d = in_tvalid;
                tmp_beat_d  = in_beat;
            end
        end else if (out_tready) begin
            out_valid_d = tmp_valid_q;
            out_beat_d  = tmp_beat_q;
            tmp_valid_d = 1'b0;
        end
    end

    // Valid and ready flags, cleared on reset so buffered beats are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            tmp_valid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            tmp_valid_q <= tmp_valid_d;
            ready_q     <= ready_d;
        end
    end

    // Beat storage needs no reset; validity is tracked by the flags above.
    always_ff @(posedge clk) begin
        out_beat_q <= out_beat_d;
        tmp_beat_q <= tmp_beat_d;
    end

    assign in_tready = ready_q;
`else
    assign in_tready = !out_valid_q || out_tready;

    // Single register: load whenever the slot is empty or being drained.
    always_comb begin
        out_valid_d = out_valid_q;
        out_beat_d  = out_beat_q;
        if (in_tready) begin
            out_valid_d = in_tvalid;
            out_beat_d  = in_beat;
        end
    end

    // Output valid flag, cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    // Beat storage needs no reset.
    always_ff @(posedge clk) begin
        out_beat_q <= out_beat_d;
    end
`endif

    assign {out_tdata, out_tkeep, out_tuser, out_tlast} = out_beat_q;
    assign out_tvalid = out_valid_q;

endmodule

// File: rtl/udp_demux.sv
// UDP frame demultiplexer: routes one header+payload frame at a time to the
// port chosen by select (sampled at header acceptance), or discards it when drop.
// Optional macro UDP_DEMUX_SKID_EN selects skid buffering in udp_demux_out_buf.
module udp_demux
    import udp_pkg::*;
#(
    parameter int M_COUNT     = 4,
    parameter int DATA_WIDTH  = 8,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int USER_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_udp_hdr_valid,
    output logic                             s_udp_hdr_ready,
    input  logic [UDP_HDR_WIDTH-1:0]         s_udp_hdr,
    input  logic [DATA_WIDTH-1:0]            s_udp_payload_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_udp_payload_axis_tkeep,
    input  logic                             s_udp_payload_axis_tvalid,
    output logic                             s_udp_payload_axis_tready,
    input  logic                             s_udp_payload_axis_tlast,
    input  logic [USER_WIDTH-1:0]            s_udp_payload_axis_tuser,
    output logic [M_COUNT-1:0]               m_udp_hdr_valid,
    input  logic [M_COUNT-1:0]               m_udp_hdr_ready,
    output logic [M_COUNT*UDP_HDR_WIDTH-1:0] m_udp_hdr,
    output logic [M_COUNT*DATA_WIDTH-1:0]    m_udp_payload_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0]    m_udp_payload_axis_tkeep,
    output logic [M_COUNT-1:0]               m_udp_payload_axis_tvalid,
    input  logic [M_COUNT-1:0]               m_udp_payload_axis_tready,
    output logic [M_COUNT-1:0]               m_udp_payload_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0]    m_udp_payload_axis_tuser,
    input  logic                             enable,
    input  logic                             drop,
    input  logic [$clog2(M_COUNT)-1:0]       select
);

    localparam int SEL_WIDTH = $clog2(M_COUNT);

    demux_state_t                            state_q, state_d;
    logic [SEL_WIDTH-1:0]                    sel_q, sel_d;
    logic                                    drop_q, drop_d;
    logic                                    hdr_ok_q, hdr_ok_d;
    logic [M_COUNT-1:0]                      hdr_valid_q, hdr_valid_d;
    logic [M_COUNT-1:0][UDP_HDR_WIDTH-1:0]   hdr_q, hdr_d;

    logic                                    drop_eff;
    logic                                    port_free;
    logic                                    hdr_accept;
    logic                                    sel_buf_ready;
    logic                                    pay_last;
    logic [KEEP_WIDTH-1:0]                   keep_in;
    logic [M_COUNT-1:0]                      buf_in_valid;
    logic [M_COUNT-1:0]                      buf_in_ready;

    assign keep_in = KEEP_ENABLE ? s_udp_payload_axis_tkeep : {KEEP_WIDTH{1'b1}};

    // Header-side handshake: an out-of-range select is treated as a drop.
    // hdr_ok_q keeps ready low for the first cycle after reset and while a frame is open.
    always_comb begin
        port_free = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (SEL_WIDTH'(i) == select && !hdr_valid_q[i]) begin
                port_free = 1'b1;
            end
        end
        drop_eff        = drop || (32'(select) >= M_COUNT);
        s_udp_hdr_ready = hdr_ok_q && enable && (drop_eff || port_free);
        hdr_accept      = s_udp_hdr_valid && s_udp_hdr_ready;
    end

    // Payload-side ready follows the latched port's buffer, or always ready when dropping.
    always_comb begin
        sel_buf_ready = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (SEL_WIDTH'(i) == sel_q) begin
                sel_buf_ready = buf_in_ready[i];
            end
        end
        s_udp_payload_axis_tready = (state_q == ST_ACTIVE) && (drop_q || sel_buf_ready);
        pay_last = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready
                   && s_udp_payload_axis_tlast;
    end

    // Next-state logic for the frame FSM and the per-port header registers.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        drop_d      = drop_q;
        hdr_valid_d = hdr_valid_q & ~m_udp_hdr_ready;
        hdr_d       = hdr_q;
        case (state_q)
            ST_IDLE: begin
                if (hdr_accept) begin
                    state_d = ST_ACTIVE;
                    sel_d   = select;
                    drop_d  = drop_eff;
                end
            end
            ST_ACTIVE: begin
                if (pay_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        hdr_ok_d = (state_d == ST_IDLE);
        for (int i = 0; i < M_COUNT; i++) begin
            if (hdr_accept && !drop_eff && SEL_WIDTH'(i) == select) begin
                hdr_valid_d[i] = 1'b1;
                hdr_d[i]       = s_udp_hdr;
            end
        end
    end

    // FSM and control flops; reset abandons any open frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            drop_q      <= 1'b0;
            hdr_ok_q    <= 1'b0;
            hdr_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            drop_q      <= drop_d;
            hdr_ok_q    <= hdr_ok_d;
            hdr_valid_q <= hdr_valid_d;
        end
    end

    // Header data registers need no reset.
    always_ff @(posedge clk) begin
        hdr_q <= hdr_d;
    end

    assign m_udp_hdr_valid = hdr_valid_q;
    assign m_udp_hdr       = hdr_q;

    for (genvar i = 0; i < M_COUNT; i++) begin : g_port
        assign buf_in_valid[i] = s_udp_payload_axis_tvalid && (state_q == ST_ACTIVE)
                                 && !drop_q && (sel_q == SEL_WIDTH'(i));

        udp_demux_out_buf #(
            .DATA_WIDTH (DATA_WIDTH),
            .KEEP_WIDTH (KEEP_WIDTH),
            .USER_WIDTH (USER_WIDTH)
        ) u_out_buf (
            .clk        (clk),
            .rst        (rst),
            .in_tdata   (s_udp_payload_axis_tdata),
            .in_tkeep   (keep_in),
            .in_tlast   (s_udp_payload_axis_tlast),
            .in_tuser   (s_udp_payload_axis_tuser),
            .in_tvalid  (buf_in_valid[i]),
            .in_tready  (buf_in_ready[i]),
            .out_tdata  (m_udp_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]),
            .out_tkeep  (m_udp_payload_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH]),
            .out_tlast  (m_udp_payload_axis_tlast[i]),
            .out_tuser  (m_udp_payload_axis_tuser[i*USER_WIDTH +: USER_WIDTH]),
            .out_tvalid (m_udp_payload_axis_tvalid[i]),
            .out_tready (m_udp_payload_axis_tready[i])
        );
    end

endmodule

// File: tb/tb_udp_demux.sv
// Directed self-checking bench for udp_demux (M_COUNT=4, 8-bit payload).
module tb_udp_demux;
    import udp_pkg::*;

    localparam int M  = 4;
    localparam int DW = 8;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         s_udp_hdr_valid;
    logic                         s_udp_hdr_ready;
    logic [UDP_HDR_WIDTH-1:0]     s_udp_hdr;
    logic [DW-1:0]                s_udp_payload_axis_tdata;
    logic [0:0]                   s_udp_payload_axis_tkeep;
    logic                         s_udp_payload_axis_tvalid;
    logic                         s_udp_payload_axis_tready;
    logic                         s_udp_payload_axis_tlast;
    logic [0:0]                   s_udp_payload_axis_tuser;
    logic [M-1:0]                 m_udp_hdr_valid;
    logic [M-1:0]                 m_udp_hdr_ready;
    logic [M*UDP_HDR_WIDTH-1:0]   m_udp_hdr;
    logic [M*DW-1:0]              m_udp_payload_axis_tdata;
    logic [M-1:0]                 m_udp_payload_axis_tkeep;
    logic [M-1:0]                 m_udp_payload_axis_tvalid;
    logic [M-1:0]                 m_udp_payload_axis_tready;
    logic [M-1:0]                 m_udp_payload_axis_tlast;
    logic [M-1:0]                 m_udp_payload_axis_tuser;
    logic                         enable;
    logic                         drop;
    logic [1:0]                   select;

    int n_assert = 0;
    int n_fail   = 0;
    int unsigned cyc = 0;
    logic toggle_en = 1'b0;

    logic [12:0]              beat_q[$];
    logic [UDP_HDR_WIDTH-1:0] hdr_q[$];
    int                       hdr_port_q[$];
    logic [M-1:0]             pay_seen;
    logic [M-1:0]             hdr_seen;

    udp_demux dut (
        .clk                       (clk),
        .rst                       (rst),
        .s_udp_hdr_valid           (s_udp_hdr_valid),
        .s_udp_hdr_ready           (s_udp_hdr_ready),
        .s_udp_hdr                 (s_udp_hdr),
        .s_udp_payload_axis_tdata  (s_udp_payload_axis_tdata),
        .s_udp_payload_axis_tkeep  (s_udp_payload_axis_tkeep),
        .s_udp_payload_axis_tvalid (s_udp_payload_axis_tvalid),
        .s_udp_payload_axis_tready (s_udp_payload_axis_tready),
        .s_udp_payload_axis_tlast  (s_udp_payload_axis_tlast),
        .s_udp_payload_axis_tuser  (s_udp_payload_axis_tuser),
        .m_udp_hdr_valid           (m_udp_hdr_valid),
        .m_udp_hdr_ready           (m_udp_hdr_ready),
        .m_udp_hdr                 (m_udp_hdr),
        .m_udp_payload_axis_tdata  (m_udp_payload_axis_tdata),
        .m_udp_payload_axis_tkeep  (m_udp_payload_axis_tkeep),
        .m_udp_payload_axis_tvalid (m_udp_payload_axis_tvalid),
        .m_udp_payload_axis_tready (m_udp_payload_axis_tready),
        .m_udp_payload_axis_tlast  (m_udp_payload_axis_tlast),
        .m_udp_payload_axis_tuser  (m_udp_payload_axis_tuser),
        .enable                    (enable),
        .drop                      (drop),
        .select                    (select)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Port 0 payload ready toggles every cycle while toggle_en is set.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) m_udp_payload_axis_tready[0] = ~m_udp_payload_axis_tready[0];
        end
    end

    // Monitor: record every output transfer; inputs only change just after posedge.
    always @(negedge clk) begin
        for (int p = 0; p < M; p++) begin
            if (m_udp_payload_axis_tvalid[p]) pay_seen[p] = 1'b1;
            if (m_udp_hdr_valid[p]) hdr_seen[p] = 1'b1;
            if (m_udp_payload_axis_tvalid[p] && m_udp_payload_axis_tready[p])
                beat_q.push_back({4'(p), m_udp_payload_axis_tlast[p],
                                  m_udp_payload_axis_tdata[p*DW +: DW]});
            if (m_udp_hdr_valid[p] && m_udp_hdr_ready[p]) begin
                hdr_q.push_back(m_udp_hdr[p*UDP_HDR_WIDTH +: UDP_HDR_WIDTH]);
                hdr_port_q.push_back(p);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [UDP_HDR_WIDTH-1:0] mk_hdr(input logic [7:0] s);
        logic [UDP_HDR_WIDTH-1:0] h;
        h = '0;
        h[ETH_DEST_MAC_OFFSET  +: 48] = {6{s}};
        h[ETH_SRC_MAC_OFFSET   +: 48] = {6{~s}};
        h[ETH_TYPE_OFFSET      +: 16] = 16'h0800;
        h[IP_VERSION_OFFSET    +: 4]  = 4'd4;
        h[IP_IHL_OFFSET        +: 4]  = 4'd5;
        h[IP_DSCP_OFFSET       +: 6]  = s[5:0];
        h[IP_ECN_OFFSET        +: 2]  = s[7:6];
        h[IP_LENGTH_OFFSET     +: 16] = {8'h00, s};
        h[IP_ID_OFFSET         +: 16] = {s, s};
        h[IP_FLAGS_OFFSET      +: 3]  = 3'b010;
        h[IP_FRAG_OFFSET       +: 13] = {5'd0, s};
        h[IP_TTL_OFFSET        +: 8]  = 8'd64;
        h[IP_PROTOCOL_OFFSET   +: 8]  = 8'd17;
        h[IP_HDR_CSUM_OFFSET   +: 16] = {~s, s};
        h[IP_SRC_IP_OFFSET     +: 32] = {8'd10, 8'd0, 8'd0, s};
        h[IP_DEST_IP_OFFSET    +: 32] = {8'd10, 8'd0, 8'd1, s};
        h[UDP_SRC_PORT_OFFSET  +: 16] = 16'd1000 + 16'(s);
        h[UDP_DEST_PORT_OFFSET +: 16] = 16'd2000 + 16'(s);
        h[UDP_LENGTH_OFFSET    +: 16] = 16'd8 + 16'(s);
        h[UDP_CSUM_OFFSET      +: 16] = {s, ~s};
        return h;
    endfunction

    task automatic send_hdr(input logic [1:0] sel, input logic drp,
                            input logic [UDP_HDR_WIDTH-1:0] h, output int waited);
        waited          = 0;
        s_udp_hdr       = h;
        select          = sel;
        drop            = drp;
        enable          = 1'b1;
        s_udp_hdr_valid = 1'b1;
        @(negedge clk);
        while (!s_udp_hdr_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!s_udp_hdr_ready) check("hdr_timeout", s_udp_hdr_ready, 1);
        @(posedge clk);
        #1;
        s_udp_hdr_valid = 1'b0;
        select          = 2'd0;
        drop            = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l);
        int n = 0;
        s_udp_payload_axis_tdata  = d;
        s_udp_payload_axis_tlast  = l;
        s_udp_payload_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_udp_payload_axis_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_udp_payload_axis_tready) check("beat_timeout", s_udp_payload_axis_tready, 1);
        @(posedge clk);
        #1;
        s_udp_payload_axis_tvalid = 1'b0;
        s_udp_payload_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame(input logic [1:0] sel, input logic [7:0] base, input int n);
        int w;
        send_hdr(sel, 1'b0, mk_hdr(base), w);
        for (int i = 0; i < n; i++) send_beat(base + 8'(i), (i == n - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        beat_q.delete();
        hdr_q.delete();
        hdr_port_q.delete();
        pay_seen = '0;
        hdr_seen = '0;
    endtask

    // Compare collected beats against port/base/length, one header expected.
    task automatic check_frame(input string tag, input int port, input logic [7:0] base, input int n);
        logic [12:0] b;
        check({tag, "_nbeats"}, beat_q.size(), n);
        check({tag, "_nhdr"}, hdr_q.size(), 1);
        if (hdr_q.size() > 0) begin
            check({tag, "_hdr_port"}, hdr_port_q[0], port);
            check({tag, "_hdr_data"}, hdr_q[0] == mk_hdr(base), 1);
        end
        for (int i = 0; i < n && i < beat_q.size(); i++) begin
            b = beat_q[i];
            check({tag, "_beat"}, b, {4'(port), (i == n - 1) ? 1'b1 : 1'b0, base + 8'(i)});
        end
    endtask

    initial begin
        int w;
        int unsigned t0;
        logic [UDP_HDR_WIDTH-1:0] h;

        rst                       = 1'b1;
        s_udp_hdr_valid           = 1'b0;
        s_udp_hdr                 = '0;
        s_udp_payload_axis_tdata  = '0;
        s_udp_payload_axis_tkeep  = 1'b1;
        s_udp_payload_axis_tvalid = 1'b0;
        s_udp_payload_axis_tlast  = 1'b0;
        s_udp_payload_axis_tuser  = 1'b0;
        m_udp_hdr_ready           = '1;
        m_udp_payload_axis_tready = '1;
        enable                    = 1'b1;
        drop                      = 1'b0;
        select                    = 2'd0;
        pay_seen                  = '0;
        hdr_seen                  = '0;

        // Reset state
        idle(2);
        check("rst_hdr_valid", m_udp_hdr_valid, 0);
        check("rst_pay_valid", m_udp_payload_axis_tvalid, 0);
        check("rst_s_hdr_ready", s_udp_hdr_ready, 0);
        check("rst_s_tready", s_udp_payload_axis_tready, 0);
        rst = 1'b0;
        idle(2);
        clear_mon();

        // Frame of 5 beats to port 2, with latency checks on header and first beat
        h = mk_hdr(8'h01);
        send_hdr(2'd2, 1'b0, h, w);
        check("t1_hdr_latency", m_udp_hdr_valid, 4'b0100);
        check("t1_hdr_ready_active", s_udp_hdr_ready, 0);
        send_beat(8'h01, 1'b0);
        check("t1_beat_latency", m_udp_payload_axis_tvalid, 4'b0100);
        check("t1_beat_data", m_udp_payload_axis_tdata[2*DW +: DW], 8'h01);
        for (int i = 2; i <= 5; i++) send_beat(8'(i), (i == 5));
        idle(3);
        check_frame("t1", 2, 8'h01, 5);
        check("t1_pay_seen", pay_seen, 4'b0100);
        check("t1_hdr_seen", hdr_seen, 4'b0100);
        clear_mon();

        // Dropped 3-beat frame: source always ready even with all outputs stalled
        m_udp_payload_axis_tready = '0;
        send_hdr(2'd0, 1'b1, mk_hdr(8'hd0), w);
        for (int i = 0; i < 3; i++) begin
            s_udp_payload_axis_tdata  = 8'hd0 + 8'(i);
            s_udp_payload_axis_tlast  = (i == 2);
            s_udp_payload_axis_tvalid = 1'b1;
            @(negedge clk);
            check("t2_drop_tready", s_udp_payload_axis_tready, 1);
            @(posedge clk);
            #1;
        end
        s_udp_payload_axis_tvalid = 1'b0;
        s_udp_payload_axis_tlast  = 1'b0;
        m_udp_payload_axis_tready = '1;
        send_hdr(2'd1, 1'b0, mk_hdr(8'h10), w);
        check("t2_hdr_next_cycle", w, 0);
        for (int i = 0; i < 3; i++) send_beat(8'h10 + 8'(i), (i == 2));
        idle(3);
        check_frame("t2", 1, 8'h10, 3);
        check("t2_pay_seen", pay_seen, 4'b0010);
        clear_mon();

        // 64-beat frame to port 0 with output ready toggling
        toggle_en = 1'b1;
        send_frame(2'd0, 8'h00, 64);
        idle(6);
        toggle_en = 1'b0;
        m_udp_payload_axis_tready = '1;
        idle(2);
        check_frame("t3", 0, 8'h00, 64);
        clear_mon();

        // Throughput with outputs always ready: one beat per cycle
        send_hdr(2'd0, 1'b0, mk_hdr(8'h80), w);
        t0 = cyc;
        for (int i = 0; i < 16; i++) send_beat(8'h80 + 8'(i), (i == 15));
        check("t3_throughput_cycles", cyc - t0, 16);
        idle(3);
        check_frame("t3b", 0, 8'h80, 16);
        clear_mon();

        // enable=0 holds off header acceptance; raising it allows acceptance at the next edge
        s_udp_hdr       = mk_hdr(8'h40);
        select          = 2'd3;
        drop            = 1'b0;
        enable          = 1'b0;
        s_udp_hdr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t4_disabled_ready", s_udp_hdr_ready, 0);
        end
        enable = 1'b1;
        #1;
        check("t4_enabled_ready", s_udp_hdr_ready, 1);
        @(posedge clk);
        #1;
        s_udp_hdr_valid = 1'b0;
        check("t4_hdr_valid", m_udp_hdr_valid, 4'b1000);
        send_beat(8'h40, 1'b1);
        idle(3);
        check_frame("t4", 3, 8'h40, 1);
        clear_mon();

        // Reset after beat 2 of 6 with header and beat held at port 1
        m_udp_hdr_ready[1] = 1'b0;
        send_hdr(2'd1, 1'b0, mk_hdr(8'h21), w);
        send_beat(8'h21, 1'b0);
        send_beat(8'h22, 1'b0);
        m_udp_payload_axis_tready[1] = 1'b0;
        check("t5_pre_pay_valid", m_udp_payload_axis_tvalid, 4'b0010);
        check("t5_pre_hdr_valid", m_udp_hdr_valid, 4'b0010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_hdr_valid", m_udp_hdr_valid, 0);
        check("t5_rst_pay_valid", m_udp_payload_axis_tvalid, 0);
        check("t5_rst_s_hdr_ready", s_udp_hdr_ready, 0);
        check("t5_rst_s_tready", s_udp_payload_axis_tready, 0);
        rst = 1'b0;
        m_udp_hdr_ready           = '1;
        m_udp_payload_axis_tready = '1;
        clear_mon();
        send_frame(2'd3, 8'h30, 4);
        idle(3);
        check_frame("t5", 3, 8'h30, 4);
        check("t5_pay_seen", pay_seen, 4'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
